// File: rtl/ivector_client_if.sv
// IVector client bundle: start command, say requests, heard indications and run status.
// The master side is the client block; the slave side is the harness or IVector peer.
interface ivector_client_if;
    logic        start__ENA;
    logic [31:0] start_count;
    logic        start__RDY;
    logic        say__ENA;
    logic [31:0] say_meth;
    logic [31:0] say_v;
    logic        say__RDY;
    logic        heard__ENA;
    logic [31:0] heard_meth;
    logic [31:0] heard_v;
    logic        heard__RDY;
    logic        done;
    logic [15:0] ok_count;
    logic [15:0] err_count;
    logic        timeout;

    modport master (
        input  start__ENA, start_count, say__RDY, heard__ENA, heard_meth, heard_v,
        output start__RDY, say__ENA, say_meth, say_v, heard__RDY,
        output done, ok_count, err_count, timeout
    );

    modport slave (
        output start__ENA, start_count, say__RDY, heard__ENA, heard_meth, heard_v,
        input  start__RDY, say__ENA, say_meth, say_v, heard__RDY,
        input  done, ok_count, err_count, timeout
    );
endinterface

// File: rtl/ivector_client.sv
// IVector say/heard initiator and checker: issues N say requests with a bounded window and
// scores every heard indication. Optional watchdog under IVECTOR_CLIENT_TIMEOUT_EN.
module ivector_client #(
    parameter int NUM_METH       = 10,
    parameter int MAX_OUT        = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    ivector_client_if.master  bus
);
    localparam int MW = (NUM_METH > 1) ? $clog2(NUM_METH) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] MAX_OUT_W  = OW'(MAX_OUT);
    localparam logic [MW-1:0] METH_LAST  = MW'(NUM_METH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [31:0]                n_q, n_d;
    logic [31:0]                issued_q, issued_d;
    logic [OW-1:0]              outst_q, outst_d;
    logic [MW-1:0]              meth_ctr_q, meth_ctr_d;
    logic [15:0]                ok_q, ok_d;
    logic [15:0]                err_q, err_d;
    logic                       done_q, done_d;
    logic [NUM_METH-1:0][31:0]  exp_q, exp_d;
`ifdef IVECTOR_CLIENT_TIMEOUT_EN
    logic                       timeout_q, timeout_d;
    logic [31:0]                wdog_q, wdog_d;
`endif

    logic        say_fire;
    logic        meth_in_range;
    logic [31:0] exp_sel;
    logic        heard_ok;
    logic        heard_dec;

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    // Window test uses the registered count, so a same-cycle heard cannot open it.
    assign say_fire = (state_q == S_ISSUE) && bus.say__RDY &&
                      (outst_q < MAX_OUT_W) && (issued_q < n_q);

    assign meth_in_range = bus.heard_meth < 32'(NUM_METH);
    assign heard_dec     = bus.heard__ENA && (outst_q != '0);

    always_comb begin
        exp_sel = '0;
        for (int m = 0; m < NUM_METH; m++)
            if (bus.heard_meth == 32'(m)) exp_sel = exp_q[m];
    end

    assign heard_ok = meth_in_range && (bus.heard_v == exp_sel) && (outst_q != '0);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        issued_d   = issued_q;
        outst_d    = outst_q;
        meth_ctr_d = meth_ctr_q;
        ok_d       = ok_q;
        err_d      = err_q;
        done_d     = 1'b0;
        exp_d      = exp_q;
`ifdef IVECTOR_CLIENT_TIMEOUT_EN
        timeout_d  = timeout_q;
        wdog_d     = wdog_q;
`endif

        // Indications are scored in every state; out-of-range methods only count as errors.
        if (bus.heard__ENA) begin
            if (heard_ok) ok_d  = sat_inc(ok_q);
            else          err_d = sat_inc(err_q);
            for (int m = 0; m < NUM_METH; m++)
                if (bus.heard_meth == 32'(m)) exp_d[m] = exp_q[m] + 32'(NUM_METH);
        end

        case ({say_fire, heard_dec})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (say_fire) begin
            issued_d   = issued_q + 32'd1;
            meth_ctr_d = (meth_ctr_q == METH_LAST) ? '0 : meth_ctr_q + MW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start__ENA) begin
                    n_d      = bus.start_count;
                    ok_d     = '0;
                    err_d    = '0;
                    issued_d = '0;
`ifdef IVECTOR_CLIENT_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    for (int m = 0; m < NUM_METH; m++) exp_d[m] = 32'(m);
                    if (bus.start_count == 32'd0) done_d  = 1'b1;
                    else                          state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issued_q >= n_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (outst_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef IVECTOR_CLIENT_TIMEOUT_EN
        // Watchdog overrides the normal run: abandon outstanding requests and finish.
        if (state_q == S_IDLE) begin
            wdog_d = '0;
        end else if (say_fire || bus.heard__ENA) begin
            wdog_d = '0;
        end else if (wdog_q == 32'(TIMEOUT_CYCLES - 1)) begin
            wdog_d    = '0;
            timeout_d = 1'b1;
            outst_d   = '0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
        end else begin
            wdog_d = wdog_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            issued_q   <= '0;
            outst_q    <= '0;
            meth_ctr_q <= '0;
            ok_q       <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            for (int m = 0; m < NUM_METH; m++) exp_q[m] <= 32'(m);
`ifdef IVECTOR_CLIENT_TIMEOUT_EN
            timeout_q  <= 1'b0;
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            issued_q   <= issued_d;
            outst_q    <= outst_d;
            meth_ctr_q <= meth_ctr_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            done_q     <= done_d;
            exp_q      <= exp_d;
`ifdef IVECTOR_CLIENT_TIMEOUT_EN
            timeout_q  <= timeout_d;
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign bus.start__RDY = (state_q == S_IDLE);
    assign bus.say__ENA   = say_fire;
    assign bus.say_meth   = 32'(meth_ctr_q);
    assign bus.say_v      = issued_q;
    assign bus.heard__RDY = 1'b1;
    assign bus.done       = done_q;
    assign bus.ok_count   = ok_q;
    assign bus.err_count  = err_q;
`ifdef IVECTOR_CLIENT_TIMEOUT_EN
    assign bus.timeout    = timeout_q;
`else
    assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_ivector_client.sv
// Directed bench for ivector_client: table of loopback runs plus hand sequences for
// window stall, idle/out-of-range heard, zero-length run, mid-run reset and watchdog.
module tb_ivector_client;
    localparam int NM = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ivector_client_if bus();

    ivector_client #(.NUM_METH(NM), .MAX_OUT(16), .TIMEOUT_CYCLES(1024)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Main-process controls for the responder
    bit auto_en = 1'b0;
    bit c_en    = 1'b0;
    int c_meth  = 0;
    int c_v     = 0;
    int inj_seq = 0;
    int inj_meth = 0;
    int inj_v    = 0;

    // Responder-owned observations
    int inj_seen = 0;
    int run_fires = 0;
    int seq_err = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_fire_cyc = 0;
    int done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Responder: returns each say two cycles later when auto_en, or a one-shot injection.
    initial begin
        bit p1_vld, p2_vld, c_used;
        logic [31:0] p1_m, p1_v, p2_m, p2_v;
        p1_vld = 0; p2_vld = 0; c_used = 0;
        p1_m = 0; p1_v = 0; p2_m = 0; p2_v = 0;
        bus.heard__ENA = 1'b0;
        bus.heard_meth = '0;
        bus.heard_v    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.heard__ENA = 1'b0;
            bus.heard_meth = '0;
            bus.heard_v    = '0;
            if (inj_seq != inj_seen) begin
                inj_seen = inj_seq;
                bus.heard__ENA = 1'b1;
                bus.heard_meth = 32'(inj_meth);
                bus.heard_v    = 32'(inj_v);
            end else if (auto_en && p2_vld) begin
                bus.heard__ENA = 1'b1;
                bus.heard_meth = p2_m;
                bus.heard_v    = p2_v;
                if (c_en && !c_used && p2_m == 32'(c_meth)) begin
                    bus.heard_v = 32'(c_v);
                    c_used = 1;
                end
            end
            p2_vld = p1_vld; p2_m = p1_m; p2_v = p1_v;
            p1_vld = 0;
            if (rst) begin
                p2_vld = 0;
            end else begin
                if (bus.start__ENA && bus.start__RDY) begin
                    run_fires = 0;
                    c_used = 0;
                end
                if (bus.say__ENA) begin
                    if (bus.say_meth != 32'(run_fires % NM) || bus.say_v != 32'(run_fires))
                        seq_err++;
                    run_fires++;
                    last_fire_cyc = cyc;
                    p1_vld = auto_en;
                    p1_m = bus.say_meth;
                    p1_v = bus.say_v;
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        chk("start_rdy_before_start", 32'(bus.start__RDY), 32'd1);
        bus.start_count = 32'(n);
        bus.start__ENA  = 1'b1;
        tick();
        bus.start__ENA  = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit got);
        got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (done_cnt != base) got = 1;
        end
    endtask

    task automatic inject(input int m, input int v);
        inj_meth = m;
        inj_v    = v;
        inj_seq++;
    endtask

    typedef struct {
        int n;
        bit cor;
        int cm;
        int cv;
        int fires;
        int ok;
        int err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  base_done, base_seq;
        bit  got;

        vecs[0] = '{20, 1'b0, 0, 0,  20, 20, 0};
        vecs[1] = '{10, 1'b1, 3, 4,  10, 9,  1};
        vecs[2] = '{0,  1'b0, 0, 0,  0,  0,  0};
        vecs[3] = '{30, 1'b0, 0, 0,  30, 30, 0};
        vecs[4] = '{10, 1'b1, 9, 99, 10, 9,  1};

        rst = 1'b1;
        bus.start__ENA  = 1'b0;
        bus.start_count = '0;
        bus.say__RDY    = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_start_rdy", 32'(bus.start__RDY), 32'd1);
        chk("rst_say_ena",   32'(bus.say__ENA),   32'd0);
        chk("rst_done",      32'(bus.done),       32'd0);
        chk("rst_ok",        32'(bus.ok_count),   32'd0);
        chk("rst_err",       32'(bus.err_count),  32'd0);
        chk("rst_heard_rdy", 32'(bus.heard__RDY), 32'd1);
        chk("rst_timeout",   32'(bus.timeout),    32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Loopback runs
        for (int i = 0; i < 5; i++) begin
            auto_en = 1'b1;
            c_en   = vecs[i].cor;
            c_meth = vecs[i].cm;
            c_v    = vecs[i].cv;
            base_done = done_cnt;
            base_seq  = seq_err;
            start_run(vecs[i].n);
            wait_done(base_done, 400, got);
            chk($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
            repeat (4) tick();
            chk($sformatf("v%0d_fires", i),   32'(run_fires), 32'(vecs[i].fires));
            chk($sformatf("v%0d_ok", i),      32'(bus.ok_count), 32'(vecs[i].ok));
            chk($sformatf("v%0d_err", i),     32'(bus.err_count), 32'(vecs[i].err));
            chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt - base_done), 32'd1);
            chk($sformatf("v%0d_seq", i),     32'(seq_err - base_seq), 32'd0);
        end
        c_en = 1'b0;

        // Zero-length run: done the cycle after accept, no say
        bus.start_count = 32'd0;
        bus.start__ENA  = 1'b1;
        tick();
        bus.start__ENA  = 1'b0;
        chk("n0_done_pulse", 32'(bus.done),     32'd1);
        chk("n0_no_say",     32'(bus.say__ENA), 32'd0);
        chk("n0_idle",       32'(bus.start__RDY), 32'd1);
        tick();
        chk("n0_done_drop",  32'(bus.done),     32'd0);

        // Heard in IDLE, then out-of-range method
        auto_en = 1'b0;
        inject(0, 0);
        repeat (3) tick();
        chk("idle_heard_err", 32'(bus.err_count), 32'd1);
        chk("idle_heard_ok",  32'(bus.ok_count),  32'd0);
        inject(12, 0);
        repeat (3) tick();
        chk("oor_heard_err",  32'(bus.err_count), 32'd2);

        // Outstanding window
        start_run(40);
        chk("win_first_say_latency", 32'(bus.say__ENA), 32'd1);
        repeat (30) tick();
        chk("win_fires_full", 32'(run_fires),    32'd16);
        chk("win_say_off",    32'(bus.say__ENA), 32'd0);
        inject(0, 0);
        repeat (5) tick();
        chk("win_one_more",   32'(run_fires),    32'd17);
        chk("win_ok1",        32'(bus.ok_count), 32'd1);
        bus.say__RDY = 1'b0;
        inject(1, 1);
        repeat (5) tick();
        chk("win_rdy_low_fires", 32'(run_fires),    32'd17);
        chk("win_rdy_low_say",   32'(bus.say__ENA), 32'd0);
        chk("win_ok2",           32'(bus.ok_count), 32'd2);
        rst = 1'b1;
        tick();
        bus.say__RDY = 1'b1;
        chk("win_rst_idle", 32'(bus.start__RDY), 32'd1);
        chk("win_rst_ok",   32'(bus.ok_count),   32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Reset mid-run after five requests
        auto_en = 1'b1;
        base_done = done_cnt;
        start_run(20);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (run_fires >= 5) got = 1;
            else tick();
        end
        chk("mid_reached5", 32'(run_fires), 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_rst_start_rdy", 32'(bus.start__RDY), 32'd1);
        chk("mid_rst_say",       32'(bus.say__ENA),   32'd0);
        chk("mid_rst_ok",        32'(bus.ok_count),   32'd0);
        chk("mid_rst_err",       32'(bus.err_count),  32'd0);
        chk("mid_rst_done",      32'(bus.done),       32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("mid_no_done", 32'(done_cnt - base_done), 32'd0);
        chk("mid_idle",    32'(bus.start__RDY),      32'd1);

`ifdef IVECTOR_CLIENT_TIMEOUT_EN
        // Watchdog: no responses, done 1024 cycles after last fire edge
        auto_en = 1'b0;
        base_done = done_cnt;
        start_run(3);
        wait_done(base_done, 1500, got);
        chk("wd_done_seen", 32'(got), 32'd1);
        chk("wd_timeout",   32'(bus.timeout), 32'd1);
        chk("wd_fires",     32'(run_fires), 32'd3);
        chk("wd_latency",   32'(done_cyc - last_fire_cyc), 32'd1025);
        tick();
        start_run(0);
        chk("wd_clear", 32'(bus.timeout), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
